// File: rtl/apb_event_conditioner.sv
// APB event conditioner: synchronises raw event lines, detects edges and levels, and drives conditioned
// pulses plus sticky status. Define GLITCH_FILTER_EN to add the per-line programmable glitch filter.
module apb_event_conditioner #(
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [31:0]               event_i,
    output logic [31:0]               signal_o,
    output logic                      event_pending_o
);

    localparam logic [3:0] REG_MODE_LO = 4'd0;
    localparam logic [3:0] REG_MODE_HI = 4'd1;
    localparam logic [3:0] REG_LEVEL   = 4'd2;
    localparam logic [3:0] REG_STATUS  = 4'd3;
    localparam logic [3:0] REG_FILTER  = 4'd4;
    localparam logic [3:0] REG_RAW     = 4'd5;

    logic        wr_en;
    logic        rd_en;
    logic [3:0]  reg_idx;

    logic [31:0] mode_lo_q;
    logic [31:0] mode_hi_q;
    logic [31:0] level_q;
    logic [31:0] status_q;
    logic [31:0] status_d;
    logic [31:0] sync1_q;
    logic [31:0] sync2_q;
    logic [31:0] prev_q;
    logic [31:0] rise_q;
    logic [31:0] fall_q;
    logic [31:0] signal_q;
    logic [31:0] signal_d;
    logic        pending_q;

    logic [31:0] acc;
    logic [31:0] en_rise;
    logic [31:0] en_fall;
    logic [31:0] sts_clr;
    logic [31:0] filter_rd;

    logic        unused_paddr;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_en   = PSEL & PENABLE & ~PWRITE;
    assign reg_idx = PADDR[5:2];

    assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

    assign PREADY          = 1'b1;
    assign PSLVERR         = 1'b0;
    assign signal_o        = signal_q;
    assign event_pending_o = pending_q;

`ifdef GLITCH_FILTER_EN
    logic [3:0]  filter_q;
    logic [31:0] filt_q;
    logic [31:0] filt_d;
    logic [3:0]  cnt_q [32];
    logic [3:0]  cnt_d [32];

    // In bypass the filtered level shadows sync2 so enabling the filter later does not create an edge.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = 4'd0;
            if (filter_q == 4'd0) begin
                filt_d[i] = sync1_q[i];
            end else if (sync2_q[i] != filt_q[i]) begin
                if (({1'b0, cnt_q[i]} + 5'd1) >= {1'b0, filter_q}) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            filter_q <= 4'd0;
            filt_q   <= '0;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (wr_en && reg_idx == REG_FILTER) begin
                filter_q <= PWDATA[3:0];
            end
        end
    end

    assign acc       = (filter_q == 4'd0) ? sync2_q : filt_q;
    assign filter_rd = {28'd0, filter_q};
`else
    assign acc       = sync2_q;
    assign filter_rd = '0;
`endif

    always_comb begin
        en_rise = '0;
        en_fall = '0;
        for (int i = 0; i < 16; i++) begin
            en_rise[i]      = mode_lo_q[2*i];
            en_fall[i]      = mode_lo_q[2*i+1];
            en_rise[i+16]   = mode_hi_q[2*i];
            en_fall[i+16]   = mode_hi_q[2*i+1];
        end
    end

    // Detection always runs; the mode bits only gate what reaches the output register.
    always_comb begin
        signal_d = (level_q & (en_rise | en_fall) & prev_q)
                 | (~level_q & ((rise_q & en_rise) | (fall_q & en_fall)));
        sts_clr  = (wr_en && reg_idx == REG_STATUS) ? PWDATA : 32'd0;
        status_d = (status_q & ~sts_clr) | signal_d;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mode_lo_q <= '0;
            mode_hi_q <= '0;
            level_q   <= '0;
            status_q  <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            signal_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= event_i;
            sync2_q   <= sync1_q;
            prev_q    <= acc;
            rise_q    <= acc & ~prev_q;
            fall_q    <= ~acc & prev_q;
            signal_q  <= signal_d;
            status_q  <= status_d;
            pending_q <= |status_q;
            if (wr_en) begin
                case (reg_idx)
                    REG_MODE_LO: mode_lo_q <= PWDATA;
                    REG_MODE_HI: mode_hi_q <= PWDATA;
                    REG_LEVEL:   level_q   <= PWDATA;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            case (reg_idx)
                REG_MODE_LO: PRDATA = mode_lo_q;
                REG_MODE_HI: PRDATA = mode_hi_q;
                REG_LEVEL:   PRDATA = level_q;
                REG_STATUS:  PRDATA = status_q;
                REG_FILTER:  PRDATA = filter_rd;
                REG_RAW:     PRDATA = sync2_q;
                default:     PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_event_conditioner.sv
// Scoreboard bench for apb_event_conditioner: a cycle-level reference model predicts signal_o,
// event_pending_o and every APB read; a monitor compares them on the falling clock edge.
module tb_apb_event_conditioner;
    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [AW-1:0] PADDR = '0;
    logic [31:0]   PWDATA = '0;
    logic          PWRITE = 1'b0;
    logic          PSEL = 1'b0;
    logic          PENABLE = 1'b0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [31:0]   event_i = '0;
    logic [31:0]   signal_o;
    logic          event_pending_o;

    logic [31:0]   ev_dir = '0;
    logic          rand_ev = 1'b0;
    int            tog_div = 3;

    int n_checks = 0;
    int n_pass = 0;

    logic [32:0] exp_sig_q[$];
    logic [31:0] exp_rd_q[$];

    // reference model state
    logic [31:0] m_mode_lo, m_mode_hi, m_level, m_status, m_e_last, m_filt;
    logic [3:0]  m_filter;
    logic        m_pend;
    logic [31:0] m_s2h [16];
    logic [31:0] m_acch [3];

    apb_event_conditioner #(.APB_ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .event_i(event_i), .signal_o(signal_o), .event_pending_o(event_pending_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge HCLK); #1; end
    endtask

    task automatic apb_write(input logic [3:0] idx, input logic [31:0] d);
        logic [5:0] up;
        up = 6'($urandom);
        PADDR = {up, idx, 2'b00}; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] idx);
        logic [5:0] up;
        up = 6'($urandom);
        PADDR = {up, idx, 2'b00}; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // event driver: directed value or random sparse toggles
    initial forever begin
        logic [31:0] t;
        @(posedge HCLK); #2;
        if (rand_ev) begin
            t = $urandom;
            for (int k = 1; k < tog_div; k++) t = t & $urandom;
            event_i = event_i ^ t;
        end else begin
            event_i = ev_dir;
        end
    end

    function automatic logic [1:0] mode_of(input int b);
        logic [1:0] m;
        if (b < 16) m = m_mode_lo[2*b +: 2];
        else        m = m_mode_hi[2*(b-16) +: 2];
        return m;
    endfunction

    // Reference model: the accepted level is sync2 (two samples behind event_i), or, when filtered,
    // it changes only once the last N sync2 samples all disagree with it. Output sees accepted
    // levels two and three cycles old.
    always @(posedge HCLK) begin
        logic [31:0] s2, sig, clr, acc;
        logic [3:0]  n_old;
        logic        all_diff, pnew, r, f;
        logic [1:0]  md;
        if (!HRESETn) begin
            m_mode_lo = '0; m_mode_hi = '0; m_level = '0; m_status = '0; m_e_last = '0;
            m_filt = '0; m_filter = '0; m_pend = 1'b0;
            for (int j = 0; j < 16; j++) m_s2h[j] = '0;
            for (int j = 0; j < 3; j++) m_acch[j] = '0;
        end else begin
            s2 = m_e_last;
            for (int j = 15; j > 0; j--) m_s2h[j] = m_s2h[j-1];
            m_s2h[0] = s2;
            n_old = m_filter;
            if (n_old == 4'd0) m_filt = s2;
            else begin
                for (int b = 0; b < 32; b++) begin
                    all_diff = 1'b1;
                    for (int j = 1; j <= int'(n_old); j++)
                        if (m_s2h[j][b] == m_filt[b]) all_diff = 1'b0;
                    if (all_diff) m_filt[b] = ~m_filt[b];
                end
            end
            sig = '0;
            for (int b = 0; b < 32; b++) begin
                md = mode_of(b);
                r = m_acch[1][b] & ~m_acch[2][b];
                f = ~m_acch[1][b] & m_acch[2][b];
                if (md == 2'b00)    sig[b] = 1'b0;
                else if (m_level[b]) sig[b] = m_acch[1][b];
                else sig[b] = (md[0] & r) | (md[1] & f);
            end
            clr = (PSEL && PENABLE && PWRITE && PADDR[5:2] == 4'd3) ? PWDATA : 32'd0;
            pnew = |m_status;
            m_status = (m_status & ~clr) | sig;
            m_pend = pnew;
            exp_sig_q.push_back({m_pend, sig});
            if (PSEL && PENABLE && PWRITE) begin
                case (PADDR[5:2])
                    4'd0: m_mode_lo = PWDATA;
                    4'd1: m_mode_hi = PWDATA;
                    4'd2: m_level   = PWDATA;
`ifdef GLITCH_FILTER_EN
                    4'd4: m_filter  = PWDATA[3:0];
`endif
                    default: ;
                endcase
            end
            acc = (m_filter == 4'd0) ? s2 : m_filt;
            m_acch[2] = m_acch[1]; m_acch[1] = m_acch[0]; m_acch[0] = acc;
            m_e_last = event_i;
            if (PSEL && !PENABLE && !PWRITE) begin
                case (PADDR[5:2])
                    4'd0: exp_rd_q.push_back(m_mode_lo);
                    4'd1: exp_rd_q.push_back(m_mode_hi);
                    4'd2: exp_rd_q.push_back(m_level);
                    4'd3: exp_rd_q.push_back(m_status);
                    4'd4: exp_rd_q.push_back({28'd0, m_filter});
                    4'd5: exp_rd_q.push_back(s2);
                    default: exp_rd_q.push_back(32'd0);
                endcase
            end
        end
    end

    // Monitor
    always @(negedge HCLK) begin
        logic [32:0] e;
        logic [31:0] er;
        if (!HRESETn) begin
            chk("reset_outputs", {event_pending_o, signal_o}, 33'd0);
            exp_sig_q.delete();
            exp_rd_q.delete();
        end else begin
            if (exp_sig_q.size() == 0) begin
                n_checks++;
                $display("FAIL sig_queue: got no expected entry, required one (t=%0t)", $time);
            end else begin
                e = exp_sig_q.pop_front();
                chk("signal_pending", {event_pending_o, signal_o}, e);
            end
            if (PSEL && PENABLE && !PWRITE) begin
                if (exp_rd_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL rd_queue: got no expected entry, required one (t=%0t)", $time);
                end else begin
                    er = exp_rd_q.pop_front();
                    chk($sformatf("prdata_idx%0d", PADDR[5:2]), {1'b0, PRDATA}, {1'b0, er});
                end
                chk("pready_pslverr", {31'd0, PREADY, PSLVERR}, {31'd0, 2'b10});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required the run to finish earlier");
        $fatal(1);
    end

    initial begin
        logic [3:0] ix;
        int r;
        idle(3);
        @(negedge HCLK); #1; HRESETn = 1'b1;
        @(posedge HCLK); #1;
        idle(2);
        for (int i = 0; i < 8; i++) apb_read(4'(i));

        // single rising event on line 0
        apb_write(4'd0, 32'h1);
        ev_dir[0] = 1'b1;
        idle(6);
        apb_read(4'd3);
        apb_read(4'd5);
        apb_write(4'd3, 32'h1);
        apb_read(4'd3);

        // both edges on line 31, 10-cycle pulse
        apb_write(4'd1, 32'hC000_0000);
        ev_dir[31] = 1'b1;
        idle(10);
        ev_dir[31] = 1'b0;
        idle(8);

        // level mode on line 5
        apb_write(4'd2, 32'h20);
        apb_write(4'd0, 32'h401);
        ev_dir[5] = 1'b1;
        idle(6);
        ev_dir[5] = 1'b0;
        idle(8);
        apb_read(4'd3);

        // W1C colliding with a fresh line-0 edge
        ev_dir[0] = 1'b0;
        idle(6);
        apb_write(4'd3, 32'hFFFF_FFFF);
        ev_dir[0] = 1'b1;
        idle(6);
        ev_dir[0] = 1'b0;
        idle(6);
        apb_read(4'd3);
        ev_dir[0] = 1'b1;
        idle(2);
        apb_write(4'd3, 32'h1);
        apb_read(4'd3);
        apb_write(4'd3, 32'h1);
        apb_read(4'd3);

        // unmapped and read-only registers ignore writes
        apb_write(4'd5, 32'hDEAD_BEEF);
        apb_write(4'd9, 32'h1234_5678);
        apb_write(4'd4, 32'h0);
        apb_read(4'd5);
        apb_read(4'd9);
        apb_read(4'd4);

        // reset in the middle of a pulse
        ev_dir[0] = 1'b0;
        idle(5);
        ev_dir[0] = 1'b1;
        idle(4);
        HRESETn = 1'b0;
        idle(2);
        @(negedge HCLK); #1; HRESETn = 1'b1;
        @(posedge HCLK); #1;
        apb_read(4'd3);
        apb_read(4'd0);
        apb_read(4'd1);
        apb_read(4'd2);
        idle(6);

        // randomized traffic
        ev_dir = '0;
        apb_write(4'd0, $urandom);
        apb_write(4'd1, $urandom);
        apb_write(4'd2, $urandom);
        rand_ev = 1'b1;
        tog_div = 3;
        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) idle(1);
            else if (r < 7) apb_read(4'($urandom_range(0, 15)));
            else if (r < 8) apb_write(4'd3, $urandom);
            else begin
                ix = 4'($urandom_range(0, 7));
                if (ix == 4'd4 || ix == 4'd3) ix = 4'd2;
                apb_write(ix, $urandom);
            end
        end
        rand_ev = 1'b0;
        idle(6);

`ifdef GLITCH_FILTER_EN
        apb_write(4'd0, 32'h1);
        apb_write(4'd1, 32'h0);
        apb_write(4'd2, 32'h0);
        idle(8);
        apb_write(4'd4, 32'h3);
        apb_write(4'd3, 32'hFFFF_FFFF);
        apb_read(4'd4);
        idle(4);
        ev_dir[0] = 1'b1;
        idle(2);
        ev_dir[0] = 1'b0;
        idle(10);
        apb_read(4'd3);
        ev_dir[0] = 1'b1;
        idle(5);
        ev_dir[0] = 1'b0;
        idle(12);
        apb_read(4'd3);
        apb_write(4'd0, $urandom);
        apb_write(4'd1, $urandom);
        rand_ev = 1'b1;
        tog_div = 4;
        for (int it = 0; it < 800; it++) begin
            r = $urandom_range(0, 9);
            if (r < 6) idle(1);
            else if (r < 8) apb_read(4'($urandom_range(0, 7)));
            else apb_write(4'd3, $urandom);
        end
        rand_ev = 1'b0;
`endif

        ev_dir = '0;
        idle(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
